// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - borrow_in, LSB first, one full-subtractor cell
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bor_q, bor_d;
    logic               borrow_out_q, borrow_out_d;

    logic               x_bit;
    logic               y_bit;
    logic               d_bit;
    logic               bor_next;
    logic               last_bit;

    // Full-subtractor cell on the current LSBs with the registered borrow.
    assign x_bit    = sa_q[0];
    assign y_bit    = sb_q[0];
    assign d_bit    = x_bit ^ y_bit ^ bor_q;
    assign bor_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & bor_q);
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sa_q         <= '0;
            sb_q         <= '0;
            sr_q         <= '0;
            diff_q       <= '0;
            cnt_q        <= '0;
            bor_q        <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            sr_q         <= sr_d;
            diff_q       <= diff_d;
            cnt_q        <= cnt_d;
            bor_q        <= bor_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sa_d         = sa_q;
        sb_d         = sb_q;
        sr_d         = sr_q;
        diff_d       = diff_q;
        cnt_d        = cnt_q;
        bor_d        = bor_q;
        borrow_out_d = borrow_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d  = a;
                    sb_d  = b;
                    bor_d = borrow_in;
                    sr_d  = '0;
                    cnt_d = '0;
                end
            end
            S_SHIFT: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                sr_d  = {d_bit, sr_q[WIDTH-1:1]};
                bor_d = bor_next;
                cnt_d = cnt_q + 1'b1;
                // Published result only moves on DONE entry; holds through later shifts.
                if (last_bit) begin
                    diff_d       = {d_bit, sr_q[WIDTH-1:1]};
                    borrow_out_d = bor_next;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy       = (state_q == S_SHIFT);
        done       = (state_q == S_DONE);
        diff       = diff_q;
        borrow_out = borrow_out_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor (WIDTH 8 and 16)
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        borrow_in = 1'b0;
    logic        busy, done, borrow_out;
    logic [7:0]  diff;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        bin16 = 1'b0;
    logic        busy16, done16, bo16;
    logic [15:0] diff16;

    int checks = 0;
    int errors = 0;

    // Reference: phase 0 idle, 1..8 shifting, 9 done; result published on entering done.
    int          m_phase = 0;
    logic [8:0]  m_pending = '0;
    logic [7:0]  m_diff = '0;
    logic        m_bo = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
    );

    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .borrow_in(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_diff  = '0;
            m_bo    = 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_pending = {1'b0, a} - {1'b0, b} - {8'b0, borrow_in};
                m_phase   = 1;
            end
        end else if (m_phase <= 8) begin
            m_phase = m_phase + 1;
            if (m_phase == 9) begin
                m_diff = m_pending[7:0];
                m_bo   = m_pending[8];
            end
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", {31'b0, busy}, {31'b0, (m_phase >= 1 && m_phase <= 8)});
            check("done", {31'b0, done}, {31'b0, (m_phase == 9)});
            check("diff", {24'b0, diff}, {24'b0, m_diff});
            check("borrow_out", {31'b0, borrow_out}, {31'b0, m_bo});
        end
    end

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin,
                        input logic [7:0] exp_d, input logic exp_bo);
        int n;
        int busy_cnt;
        @(negedge clk);
        a = ta; b = tb_; borrow_in = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); borrow_in = 1'($urandom);
        n = 0; busy_cnt = 0;
        while (!done && n < 50) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check("latency8", n, 8);
        check("busy_cycles8", busy_cnt, 8);
        check("res_diff8", {24'b0, diff}, {24'b0, exp_d});
        check("res_bo8", {31'b0, borrow_out}, {31'b0, exp_bo});
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
        int n;
        logic [16:0] exp;
        exp = {1'b0, ta} - {1'b0, tb_} - {16'b0, tbin};
        @(negedge clk);
        a16 = ta; b16 = tb_; bin16 = tbin; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        a16 = 16'($urandom); b16 = 16'($urandom);
        n = 0;
        while (!done16 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("latency16", n, 16);
        check("res_diff16", {16'b0, diff16}, {16'b0, exp[15:0]});
        check("res_bo16", {31'b0, bo16}, {31'b0, exp[16]});
    endtask

    initial begin
        int dones;
        logic [7:0]  ra, rb;
        logic        rbin;
        logic [8:0]  rexp;

        #1 rst = 1'b1;
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_diff", {24'b0, diff}, 0);
        check("rst_bo", {31'b0, borrow_out}, 0);
        check("rst_diff16", {16'b0, diff16}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
        run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1);
        run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        run8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);

        // start during SHIFT must be ignored
        @(negedge clk);
        a = 8'h80; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (i == 2) begin
                a = 8'h11;
                start = 1'b1;
            end else begin
                start = 1'b0;
                a = a ^ 8'hFF;
            end
            b = b ^ 8'hFF;
        end
        check("ignored_dones", dones, 1);
        check("ignored_diff", {24'b0, diff}, 32'h7F);
        check("ignored_bo", {31'b0, borrow_out}, 0);
        check("ignored_idle", {31'b0, busy}, 0);

        // start held high: back-to-back operations every 10 cycles
        @(negedge clk);
        a = 8'h10; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                check("hold_diff", {24'b0, diff}, 32'h0F);
            end
        end
        start = 1'b0;
        check("hold_dones", dones, 3);
        repeat (12) @(negedge clk);

        // asynchronous reset mid-SHIFT
        @(negedge clk);
        a = 8'hAA; b = 8'h55; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_done", {31'b0, done}, 0);
        check("arst_diff", {24'b0, diff}, 0);
        check("arst_bo", {31'b0, borrow_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        run8(8'h0A, 8'h0A, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
            rexp = {1'b0, ra} - {1'b0, rb} - {8'b0, rbin};
            run8(ra, rb, rbin, rexp[7:0], rexp[8]);
        end

        run16(16'h0005, 16'h0003, 1'b0);
        run16(16'h0000, 16'h0000, 1'b1);
        check("lit16_diff", {16'b0, diff16}, 32'hFFFF);
        check("lit16_bo", {31'b0, bo16}, 1);
        for (int i = 0; i < 1000; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor, computing diff = a - b - borrow_in, one bit per clock, LSB first.
- Uses a single full-subtractor cell with a registered borrow: the subtract-direction, sequential counterpart of the team's combinational full-adder cell.
- Controlled by a start/busy/done handshake so a top-level wrapper can drive it from ui_in and read results on uo_out.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- borrow_in  input  1  initial borrow; captured on an accepted start.
- busy  output  1  high while state is SHIFT.
- done  output  1  one-cycle pulse; result valid from this cycle onward.
- diff  output  WIDTH  registered difference.
- borrow_out  output  1  final borrow (1 = a < b + borrow_in, unsigned).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow_out=0. All internal shift registers, bit counter and borrow flop clear to 0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced, and outputs return to their reset values.
- FSM states:
  - IDLE: busy=0, done=0.
    - start=1 at an edge: load sa<=a, sb<=b, bor<=borrow_in, sr<=0, cnt<=0; go to SHIFT.
    - start=0: stay in IDLE.
  - SHIFT: busy=1. Each edge processes bit x=sa[0], y=sb[0]:
    - d = x ^ y ^ bor
    - bor <= (~x & y) | (~(x ^ y) & bor)
    - sr <= {d, sr[WIDTH-1:1]}; sa, sb shift right by one; cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1 (the WIDTH-th bit): diff <= {d, sr[WIDTH-1:1]}, borrow_out <= final borrow; go to DONE.
  - DONE: done=1, busy=0 for exactly one cycle; next edge go to IDLE unconditionally.
- Handshake rules:
  - start is ignored in SHIFT and DONE. No queuing, and operands presented while busy are not captured.
  - start held high continuously gives back-to-back operations: a new capture occurs in the first IDLE cycle after DONE.
  - a, b and borrow_in may change freely after the capture edge without affecting the result.
- Latency: start sampled at edge 0. SHIFT occupies edges 1..WIDTH; done is high in the cycle after edge WIDTH (cycle WIDTH+1). Minimum start-to-start spacing is WIDTH+2 cycles.
- Output holding:
  - diff and borrow_out are updated only on DONE entry and hold until the next DONE entry or reset.
  - They do not change during a subsequent SHIFT.
- Arithmetic is unsigned modulo 2^WIDTH. borrow_out is the carry-out complement of a + ~b + ~borrow_in.
- cnt width is $clog2(WIDTH). No combinational path exists from inputs to outputs.

Test Plan:
- WIDTH=8, a=8'h05, b=8'h03, borrow_in=0, start pulse -> busy high for 8 cycles; done pulses 9 cycles after the start edge; diff=8'h02, borrow_out=0.
- a=8'h03, b=8'h05, borrow_in=0 -> diff=8'hFE, borrow_out=1. Then a=8'h00, b=8'h00, borrow_in=1 -> diff=8'hFF, borrow_out=1. Then a=8'hFF, b=8'hFF, borrow_in=0 -> diff=8'h00, borrow_out=0.
- Start accepted with a=8'h80, b=8'h01; during SHIFT pulse start again with a=8'h11 and toggle a/b every cycle -> exactly one done; diff=8'h7F, borrow_out=0; no second operation begins.
- start held high for 30 cycles with a=8'h10, b=8'h01 -> done pulses every 10 cycles, each with diff=8'h0F; busy low in each DONE and the following IDLE cycle.
- Start a=8'hAA, b=8'h55; assert rst asynchronously (mid-cycle) after 4 SHIFT cycles -> busy, done, diff, borrow_out go to 0 immediately with no clock edge. After release, a fresh start with a=8'h0A, b=8'h0A -> diff=8'h00, borrow_out=0.
- Random regression: 1000 random a, b, borrow_in triples, WIDTH=8 and WIDTH=16 -> diff and borrow_out match the reference model {borrow_out, diff} = {1'b0, a} - b - borrow_in, taken modulo 2^(WIDTH+1).
